// File: rtl/tt_um_debounce_counter.sv
// rtl/tt_um_debounce_counter.sv - debounced up/down button counter with 7-segment output
// Three synchronized, debounced buttons drive a 4-bit wrapping counter shown on a 7-segment display.

module tt_um_debounce_counter_deb #(
    parameter int unsigned DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sample,
    output logic level
);
    localparam int unsigned CW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] C_MAX = CW'(DEB_CYCLES - 1);

    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Any sample that agrees with the current level restarts the run, so glitches never accumulate.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (sample == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == C_MAX) begin
            level_d = sample;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
endmodule

module tt_um_debounce_counter #(
    parameter int unsigned DEB_CYCLES = 16
) (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);
    logic [2:0] sync1_q, sync1_d;
    logic [2:0] sync2_q, sync2_d;
    logic [2:0] deb_lvl;
    logic       cnt_lvl_q, cnt_lvl_d;
    logic       clr_lvl_q, clr_lvl_d;
    logic [3:0] count_q, count_d;
    logic       cnt_pulse;
    logic       clr_pulse;
    logic [6:0] seg;
    logic       unused;

    assign unused = ^{ui_in[7:3], uio_in};

    always_comb begin
        sync1_d = ui_in[2:0];
        sync2_d = sync1_q;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_deb
            tt_um_debounce_counter_deb #(
                .DEB_CYCLES(DEB_CYCLES)
            ) u_deb (
                .clk   (clk),
                .rst_n (rst_n),
                .sample(sync2_q[gi]),
                .level (deb_lvl[gi])
            );
        end
    endgenerate

    // Edge history runs regardless of ena so a pulse seen while disabled is simply lost.
    assign cnt_pulse = deb_lvl[0] & ~cnt_lvl_q;
    assign clr_pulse = deb_lvl[2] & ~clr_lvl_q;

    always_comb begin
        cnt_lvl_d = deb_lvl[0];
        clr_lvl_d = deb_lvl[2];
        count_d   = count_q;
        if (ena) begin
            if (clr_pulse) begin
                count_d = 4'd0;
            end else if (cnt_pulse) begin
                count_d = deb_lvl[1] ? count_q + 4'd1 : count_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q   <= 3'b000;
            sync2_q   <= 3'b000;
            cnt_lvl_q <= 1'b0;
            clr_lvl_q <= 1'b0;
            count_q   <= 4'd0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            cnt_lvl_q <= cnt_lvl_d;
            clr_lvl_q <= clr_lvl_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        seg = 7'h00;
        case (count_q)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
            default: seg = 7'h00;
        endcase
    end

    assign uo_out  = {deb_lvl[0], seg};
    assign uio_out = {4'h0, count_q};
    assign uio_oe  = 8'h0F;
endmodule

// File: tb/tb_tt_um_debounce_counter.sv
// tb/tb_tt_um_debounce_counter.sv - directed vector bench for tt_um_debounce_counter
module tb_tt_um_debounce_counter;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic       ena;
    logic       clk;
    logic       rst_n;

    int n_checks;
    int n_fail;

    tt_um_debounce_counter dut (
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe),
        .ena    (ena),
        .clk    (clk),
        .rst_n  (rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] ui;
        logic       en;
        int         cycles;
        logic [7:0] exp_uo;
        logic [7:0] exp_uio;
    } vec_t;

    vec_t vecs[19];

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic press(input logic [7:0] base);
        ui_in = base | 8'h01;
        tick(20);
        ui_in = base;
        tick(20);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
    endtask

    logic saw_high;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        ui_in    = 8'h00;
        uio_in   = 8'hA5;
        ena      = 1'b1;
        rst_n    = 1'b0;

        vecs[0]  = '{8'h02, 1'b1, 20, 8'h06, 8'h01};
        vecs[1]  = '{8'h03, 1'b1, 20, 8'hDB, 8'h02};
        vecs[2]  = '{8'h02, 1'b1, 20, 8'h5B, 8'h02};
        vecs[3]  = '{8'h00, 1'b1, 20, 8'h5B, 8'h02};
        vecs[4]  = '{8'h01, 1'b1, 20, 8'h86, 8'h01};
        vecs[5]  = '{8'h00, 1'b1, 20, 8'h06, 8'h01};
        vecs[6]  = '{8'h01, 1'b1, 20, 8'hBF, 8'h00};
        vecs[7]  = '{8'h00, 1'b1, 20, 8'h3F, 8'h00};
        vecs[8]  = '{8'h01, 1'b1, 20, 8'hF1, 8'h0F};
        vecs[9]  = '{8'h00, 1'b1, 20, 8'h71, 8'h0F};
        vecs[10] = '{8'h04, 1'b1, 20, 8'h3F, 8'h00};
        vecs[11] = '{8'h00, 1'b1, 20, 8'h3F, 8'h00};
        vecs[12] = '{8'h02, 1'b0, 20, 8'h3F, 8'h00};
        vecs[13] = '{8'h03, 1'b0, 20, 8'hBF, 8'h00};
        vecs[14] = '{8'h03, 1'b1, 20, 8'hBF, 8'h00};
        vecs[15] = '{8'h02, 1'b1, 20, 8'h3F, 8'h00};
        vecs[16] = '{8'hFA, 1'b1, 20, 8'h3F, 8'h00};
        vecs[17] = '{8'hFB, 1'b1, 20, 8'h86, 8'h01};
        vecs[18] = '{8'hFA, 1'b1, 20, 8'h06, 8'h01};

        // Reset state
        tick(2);
        chk("reset_uo", uo_out, 8'h3F);
        chk("reset_uio", uio_out, 8'h00);
        chk("reset_oe", uio_oe, 8'h0F);
        rst_n = 1'b1;

        // Exact latency: input first sampled at edge 1
        ui_in = 8'h03;
        tick(17);
        chk("lat_e17_uo", uo_out, 8'h3F);
        tick(1);
        chk("lat_e18_uo", uo_out, 8'hBF);
        chk("lat_e18_uio", uio_out, 8'h00);
        tick(1);
        chk("lat_e19_uo", uo_out, 8'h86);
        chk("lat_e19_uio", uio_out, 8'h01);

        for (int v = 0; v < 19; v++) begin
            ui_in = vecs[v].ui;
            ena   = vecs[v].en;
            tick(vecs[v].cycles);
            chk($sformatf("vec%0d_uo", v), uo_out, vecs[v].exp_uo);
            chk($sformatf("vec%0d_uio", v), uio_out, vecs[v].exp_uio);
            chk($sformatf("vec%0d_oe", v), uio_oe, 8'h0F);
        end

        // Glitch of 15 cycles is rejected, 16 cycles is accepted
        saw_high = 1'b0;
        ui_in = 8'h03;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            if (uo_out[7]) saw_high = 1'b1;
        end
        ui_in = 8'h02;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (uo_out[7]) saw_high = 1'b1;
        end
        chk("glitch15_level", {7'd0, saw_high}, 8'h00);
        chk("glitch15_uio", uio_out, 8'h01);
        ui_in = 8'h03;
        tick(16);
        ui_in = 8'h02;
        tick(20);
        chk("glitch16_uio", uio_out, 8'h02);
        chk("glitch16_uo", uo_out, 8'h5B);

        // Sixteen up presses from zero wrap back to zero
        press(8'h04);
        chk("clr_uio", uio_out, 8'h00);
        ui_in = 8'h02;
        tick(20);
        for (int i = 0; i < 15; i++) press(8'h02);
        chk("up15_uio", uio_out, 8'h0F);
        chk("up15_uo", uo_out, 8'h71);
        press(8'h02);
        chk("up16_uio", uio_out, 8'h00);
        chk("up16_uo", uo_out, 8'h3F);

        // Clear wins over a simultaneous count from 5
        for (int i = 0; i < 5; i++) press(8'h02);
        chk("five_uo", uo_out, 8'h6D);
        ui_in = 8'h07;
        tick(20);
        chk("both_uio", uio_out, 8'h00);
        chk("both_uo", uo_out, 8'hBF);
        ui_in = 8'h02;
        tick(20);

        // Reset mid-debounce at count 7, then button held through release
        for (int i = 0; i < 7; i++) press(8'h02);
        chk("seven_uo", uo_out, 8'h07);
        chk("seven_uio", uio_out, 8'h07);
        ui_in = 8'h03;
        tick(8);
        do_reset();
        chk("midrst_uo", uo_out, 8'h3F);
        chk("midrst_uio", uio_out, 8'h00);
        tick(17);
        chk("rel_e17_uo", uo_out, 8'h3F);
        tick(1);
        chk("rel_e18_uo", uo_out, 8'hBF);
        chk("rel_e18_uio", uio_out, 8'h00);
        tick(1);
        chk("rel_e19_uio", uio_out, 8'h01);
        chk("rel_e19_uo", uo_out, 8'h86);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/tt_um_debounce_counter.md
TT_UM_DEBOUNCE_COUNTER -- requirements
Module: tt_um_debounce_counter

Interface
REQ-001 Parameter: DEB_CYCLES, default 16, consecutive synchronized cycles a raw input must differ from its debounced level before the level flips; legal range 2..65535.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low; sampled on rising clk.
REQ-004 ena  input  1  design enabled; gates counter updates only.
REQ-005 ui_in  input  8  [0]=count button, [1]=direction (1 up, 0 down), [2]=clear button, [7:3] unused.
REQ-006 uo_out  output  8  [6:0]=7-segment pattern of count (a=bit0..g=bit6, active high), [7]=debounced count-button level.
REQ-007 uio_in  input  8  unused, ignored.
REQ-008 uio_out  output  8  [3:0]=count, [7:4]=0.
REQ-009 uio_oe  output  8  constant 8'h0F.

Function
REQ-010 ui_in[0], ui_in[1], ui_in[2] each SHALL pass a two-flop synchronizer before any other logic; ui_in[7:3] SHALL not affect any output.
REQ-011 Each synchronized input SHALL have its own debouncer: debounced level D, cycle counter C of width ceil(log2(DEB_CYCLES)).
REQ-012 Debouncer per edge: sample == D -> C<=0; sample != D and C < DEB_CYCLES-1 -> C<=C+1; sample != D and C == DEB_CYCLES-1 -> D<=sample, C<=0.
REQ-013 Latency: clean step on ui_in first sampled at edge 1 SHALL flip D at edge DEB_CYCLES+2; any glitch shorter than DEB_CYCLES synchronized cycles SHALL leave D unchanged and restart C.
REQ-014 Rising-edge detect on debounced count and clear levels, using a registered copy of each D; pulse = D & ~D_q.
REQ-015 Count (4-bit) SHALL update on the edge after the detect pulse asserts (edge DEB_CYCLES+3 of REQ-013), only when ena=1.
REQ-016 Count pulse with debounced direction=1 -> count+1; direction=0 -> count-1; wraps 15->0 and 0->15.
REQ-017 Clear pulse -> count<=0; clear SHALL win over a simultaneous count pulse.
REQ-018 Falling edges of any debounced input SHALL not change count.
REQ-019 Pulses occurring while ena=0 SHALL be discarded, not queued; debouncers and synchronizers run regardless of ena.
REQ-020 uo_out[6:0] SHALL be combinational from count: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71 (hex).
REQ-021 uo_out[7] SHALL equal debounced count-button level D directly.

Reset
REQ-022 rst_n=0 at a rising edge SHALL clear all synchronizer flops, all D, all D_q, all C, and count to 0.
REQ-023 During and after reset until the first count change: uo_out=8'h3F, uio_out=8'h00, uio_oe=8'h0F.
REQ-024 Reset asserted mid-debounce SHALL discard the partial count; no count pulse SHALL result from reset itself.
REQ-025 ui_in[0] held high through reset release SHALL be treated as a fresh press: D rises DEB_CYCLES+2 edges after release, count increments one edge later.

Verification
REQ-026 Reset, ui_in=0 -> uo_out=3F, uio_out=00, uio_oe=0F.
REQ-027 DEB_CYCLES=16, ena=1, dir=1: ui_in[0] high at edge 1 and held -> uo_out[7]=1 at edge 18, uio_out=01 and uo_out=86 after edge 19; release -> count stays 1.
REQ-028 Glitch: ui_in[0] high 15 cycles then low -> uo_out[7] stays 0, count stays 0; repeat with 16 cycles -> count becomes 1.
REQ-029 dir=0 from count 0, one clean press -> count=F, uo_out=71; dir=1, sixteen presses from 0 -> count returns to 0.
REQ-030 Count and clear buttons pressed in same cycle from count 5 -> count=0; press with ena=0 -> count unchanged, no update after ena returns to 1.
REQ-031 rst_n low 1 cycle while ui_in[0] debounce half-complete at count 7 -> count=0, uo_out=3F; button still held -> count=1 after DEB_CYCLES+3 edges.
